// File: rtl/simt_mask_stack.sv
// SIMT divergence/reconvergence mask stack.
// Keeps the lane active mask and a stack of divergent-branch entries.
// Executes SPLIT / ELSE / JOIN commands from the control unit and reports
// whether the current branch predicate is uniform across the active lanes.
module simt_mask_stack #(
   parameter int LANES = 4,
   parameter int DEPTH = 8,
   parameter int PC_W  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   input  logic [1:0]                 cmd,
   input  logic [LANES-1:0]           cond_mask,
   input  logic [PC_W-1:0]            else_pc,
   output logic [LANES-1:0]           active_mask,
   output logic                       all_mask_true,
   output logic                       all_mask_false,
   output logic                       redirect_valid,
   output logic [PC_W-1:0]            redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'b00,
      CMD_SPLIT = 2'b01,
      CMD_ELSE  = 2'b10,
      CMD_JOIN  = 2'b11
   } cmd_e;

   // Stack storage, one field per array
   logic [LANES-1:0] saved_q  [DEPTH];
   logic [LANES-1:0] saved_d  [DEPTH];
   logic [LANES-1:0] emask_q  [DEPTH];
   logic [LANES-1:0] emask_d  [DEPTH];
   logic [PC_W-1:0]  epc_q    [DEPTH];
   logic [PC_W-1:0]  epc_d    [DEPTH];
   logic             phase_q  [DEPTH];
   logic             phase_d  [DEPTH];

   logic [LANES-1:0] active_q, active_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             rv_q, rv_d;
   logic [PC_W-1:0]  rpc_q, rpc_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   cmd_e             cmd_w;
   logic [LANES-1:0] taken;
   logic [LANES-1:0] not_taken;
   logic             full;
   logic             empty;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    push_idx;

   assign cmd_w     = cmd_e'(cmd);
   assign taken     = active_q & cond_mask;
   assign not_taken = active_q & ~cond_mask;
   assign full      = (depth_q == DW'(DEPTH));
   assign empty     = (depth_q == '0);
   // Index arithmetic is only used when the stack is non-empty / non-full,
   // so truncation to the entry-address width is safe.
   assign top_idx   = AW'(depth_q - DW'(1));
   assign push_idx  = AW'(depth_q);

   assign all_mask_true  = (not_taken == '0);
   assign all_mask_false = (taken == '0);
   assign active_mask    = active_q;
   assign redirect_valid = rv_q;
   assign redirect_pc    = rpc_q;
   assign depth          = depth_q;
   assign overflow       = ovf_q;
   assign underflow      = udf_q;

   // Command decode: next mask, stack contents and sticky error flags
   always_comb begin
      saved_d  = saved_q;
      emask_d  = emask_q;
      epc_d    = epc_q;
      phase_d  = phase_q;
      active_d = active_q;
      depth_d  = depth_q;
      rv_d     = 1'b0;
      rpc_d    = rpc_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (cmd_valid) begin
         unique case (cmd_w)
            CMD_SPLIT: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  saved_d[push_idx] = active_q;
                  emask_d[push_idx] = not_taken;
                  epc_d[push_idx]   = else_pc;
                  phase_d[push_idx] = 1'b0;
                  active_d          = taken;
                  depth_d           = depth_q + DW'(1);
               end
            end
            CMD_ELSE: begin
               if (empty || phase_q[top_idx]) begin
                  udf_d = 1'b1;
               end else begin
                  active_d         = emask_q[top_idx];
                  phase_d[top_idx] = 1'b1;
                  rv_d             = 1'b1;
                  rpc_d            = epc_q[top_idx];
               end
            end
            CMD_JOIN: begin
               if (empty) begin
                  udf_d = 1'b1;
               end else begin
                  active_d = saved_q[top_idx];
                  depth_d  = depth_q - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // State registers; asynchronous reset discards all entries at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         saved_q  <= '{default: '0};
         emask_q  <= '{default: '0};
         epc_q    <= '{default: '0};
         phase_q  <= '{default: 1'b0};
         active_q <= '1;
         depth_q  <= '0;
         rv_q     <= 1'b0;
         rpc_q    <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         saved_q  <= saved_d;
         emask_q  <= emask_d;
         epc_q    <= epc_d;
         phase_q  <= phase_d;
         active_q <= active_d;
         depth_q  <= depth_d;
         rv_q     <= rv_d;
         rpc_q    <= rpc_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

endmodule

// File: tb/tb_simt_mask_stack.sv
// Directed bench for simt_mask_stack (LANES=4, DEPTH=8, PC_W=8).
module tb_simt_mask_stack;

   localparam logic [1:0] NOP   = 2'b00;
   localparam logic [1:0] SPLIT = 2'b01;
   localparam logic [1:0] ELSE  = 2'b10;
   localparam logic [1:0] JOIN  = 2'b11;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic [3:0] cond_mask;
   logic [7:0] else_pc;
   logic [3:0] active_mask;
   logic       all_mask_true;
   logic       all_mask_false;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic [3:0] depth;
   logic       overflow;
   logic       underflow;

   int unsigned checks = 0;
   int unsigned errors = 0;

   simt_mask_stack #(.LANES(4), .DEPTH(8), .PC_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd            (cmd),
      .cond_mask      (cond_mask),
      .else_pc        (else_pc),
      .active_mask    (active_mask),
      .all_mask_true  (all_mask_true),
      .all_mask_false (all_mask_false),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .depth          (depth),
      .overflow       (overflow),
      .underflow      (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flags are expected against the mask before the edge; the rest after it
   typedef struct {
      logic       v;
      logic [1:0] c;
      logic [3:0] cond;
      logic [7:0] epc;
      logic       at;
      logic       af;
      logic [3:0] act;
      logic [3:0] dep;
      logic       rv;
      logic [7:0] rpc;
      logic       ov;
      logic       un;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] c, input logic [3:0] cond, input logic [7:0] epc);
      @(negedge clk);
      cmd_valid = v;
      cmd       = c;
      cond_mask = cond;
      else_pc   = epc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = NOP;
   endtask

   task automatic do_reset();
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = NOP;
      reset     = 1'b0;
      @(negedge clk);
      reset     = 1'b1;
   endtask

   logic [3:0] conds [9];

   initial begin
      //          v     cmd    cond     epc    at    af    act      dep   rv    rpc    ov    un
      vecs[0]  = '{1'b1, NOP,   4'b1111, 8'h00, 1'b1, 1'b0, 4'b1111, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, NOP,   4'b0000, 8'h00, 1'b0, 1'b1, 4'b1111, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, SPLIT, 4'b0101, 8'h77, 1'b0, 1'b0, 4'b1111, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, SPLIT, 4'b0101, 8'h20, 1'b0, 1'b0, 4'b0101, 4'd1, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, ELSE,  4'b0000, 8'h00, 1'b0, 1'b1, 4'b1010, 4'd1, 1'b1, 8'h20, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, JOIN,  4'b1111, 8'h00, 1'b1, 1'b0, 4'b1111, 4'd0, 1'b0, 8'h20, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, SPLIT, 4'b0011, 8'h30, 1'b0, 1'b0, 4'b0011, 4'd1, 1'b0, 8'h20, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, SPLIT, 4'b0001, 8'h40, 1'b0, 1'b0, 4'b0001, 4'd2, 1'b0, 8'h20, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, ELSE,  4'b0000, 8'h00, 1'b0, 1'b1, 4'b0010, 4'd2, 1'b1, 8'h40, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, JOIN,  4'b0000, 8'h00, 1'b0, 1'b1, 4'b0011, 4'd1, 1'b0, 8'h40, 1'b0, 1'b0};
      vecs[10] = '{1'b1, ELSE,  4'b1100, 8'h00, 1'b0, 1'b1, 4'b1100, 4'd1, 1'b1, 8'h30, 1'b0, 1'b0};
      vecs[11] = '{1'b1, JOIN,  4'b1100, 8'h00, 1'b1, 1'b0, 4'b1111, 4'd0, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[12] = '{1'b1, SPLIT, 4'b1111, 8'h50, 1'b1, 1'b0, 4'b1111, 4'd1, 1'b0, 8'h30, 1'b0, 1'b0};
      vecs[13] = '{1'b1, ELSE,  4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 4'd1, 1'b1, 8'h50, 1'b0, 1'b0};
      vecs[14] = '{1'b1, NOP,   4'b1010, 8'h00, 1'b1, 1'b1, 4'b0000, 4'd1, 1'b0, 8'h50, 1'b0, 1'b0};
      vecs[15] = '{1'b1, ELSE,  4'b0000, 8'h00, 1'b1, 1'b1, 4'b0000, 4'd1, 1'b0, 8'h50, 1'b0, 1'b1};
      vecs[16] = '{1'b1, JOIN,  4'b0000, 8'h00, 1'b1, 1'b1, 4'b1111, 4'd0, 1'b0, 8'h50, 1'b0, 1'b1};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd       = NOP;
      cond_mask = 4'b1111;
      else_pc   = 8'h00;
      #2;
      reset     = 1'b0;
      #2;
      chk("rst active", 32'(active_mask), 32'h0000000f);
      chk("rst depth", 32'(depth), 32'd0);
      chk("rst rv", 32'(redirect_valid), 32'd0);
      chk("rst rpc", 32'(redirect_pc), 32'd0);
      chk("rst ovf", 32'(overflow), 32'd0);
      chk("rst udf", 32'(underflow), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table-driven main sequence
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         cmd_valid = vecs[i].v;
         cmd       = vecs[i].c;
         cond_mask = vecs[i].cond;
         else_pc   = vecs[i].epc;
         #1;
         chk($sformatf("v%0d all_true", i), 32'(all_mask_true), 32'(vecs[i].at));
         chk($sformatf("v%0d all_false", i), 32'(all_mask_false), 32'(vecs[i].af));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d active", i), 32'(active_mask), 32'(vecs[i].act));
         chk($sformatf("v%0d depth", i), 32'(depth), 32'(vecs[i].dep));
         chk($sformatf("v%0d rv", i), 32'(redirect_valid), 32'(vecs[i].rv));
         if (vecs[i].rv)
            chk($sformatf("v%0d rpc", i), 32'(redirect_pc), 32'(vecs[i].rpc));
         chk($sformatf("v%0d ovf", i), 32'(overflow), 32'(vecs[i].ov));
         chk($sformatf("v%0d udf", i), 32'(underflow), 32'(vecs[i].un));
      end

      // JOIN on an empty stack straight after reset
      do_reset();
      step(1'b1, JOIN, 4'b1111, 8'h00);
      chk("ujoin udf", 32'(underflow), 32'd1);
      chk("ujoin active", 32'(active_mask), 32'h0000000f);
      chk("ujoin depth", 32'(depth), 32'd0);

      // Second ELSE on the same entry: error, no new redirect
      do_reset();
      step(1'b1, SPLIT, 4'b0110, 8'h11);
      chk("se split active", 32'(active_mask), 32'h00000006);
      step(1'b1, ELSE, 4'b0000, 8'h00);
      chk("se else1 rv", 32'(redirect_valid), 32'd1);
      chk("se else1 rpc", 32'(redirect_pc), 32'h00000011);
      chk("se else1 active", 32'(active_mask), 32'h00000009);
      chk("se else1 udf", 32'(underflow), 32'd0);
      step(1'b1, ELSE, 4'b0000, 8'h00);
      chk("se else2 rv", 32'(redirect_valid), 32'd0);
      chk("se else2 active", 32'(active_mask), 32'h00000009);
      chk("se else2 udf", 32'(underflow), 32'd1);
      chk("se else2 depth", 32'(depth), 32'd1);

      // Nine SPLITs against an eight-entry stack
      do_reset();
      for (int i = 0; i < 7; i++) conds[i] = 4'b1111;
      conds[7] = 4'b0111;
      conds[8] = 4'b0011;
      for (int i = 0; i < 8; i++) step(1'b1, SPLIT, conds[i], 8'(i));
      chk("ovf d8 depth", 32'(depth), 32'd8);
      chk("ovf d8 active", 32'(active_mask), 32'h00000007);
      chk("ovf d8 ovf", 32'(overflow), 32'd0);
      step(1'b1, SPLIT, conds[8], 8'h99);
      chk("ovf 9th depth", 32'(depth), 32'd8);
      chk("ovf 9th active", 32'(active_mask), 32'h00000007);
      chk("ovf 9th ovf", 32'(overflow), 32'd1);
      step(1'b1, JOIN, 4'b0000, 8'h00);
      chk("ovf join depth", 32'(depth), 32'd7);
      chk("ovf join active", 32'(active_mask), 32'h0000000f);
      chk("ovf join ovf", 32'(overflow), 32'd1);

      // Asynchronous reset in the middle of a nest
      do_reset();
      step(1'b1, JOIN, 4'b0000, 8'h00);
      step(1'b1, SPLIT, 4'b0111, 8'h01);
      step(1'b1, SPLIT, 4'b0011, 8'h02);
      step(1'b1, SPLIT, 4'b0001, 8'h03);
      chk("mid depth", 32'(depth), 32'd3);
      chk("mid active", 32'(active_mask), 32'h00000001);
      chk("mid udf", 32'(underflow), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      chk("arst active", 32'(active_mask), 32'h0000000f);
      chk("arst depth", 32'(depth), 32'd0);
      chk("arst udf", 32'(underflow), 32'd0);
      chk("arst ovf", 32'(overflow), 32'd0);
      idle();
      reset = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
